me_ctrl_param: RTL and testbench

//  Parametrised sequencer for the full-search block-matching motion estimator; drives the PE array, comparator and memories.

---
 rtl/me_pkg.sv | 34 +++
 rtl/me_step_counter.sv | 48 ++++
 rtl/me_ctrl_param.sv | 208 ++++++++++++++++++++
 tb/tb_me_ctrl_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and width helpers for the block-matching motion-estimator sequencer.
package me_pkg;

    // Sequencer phases: wait for start, stream candidates, flush PEs, report completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } me_state_e;

    // Default geometry: 16x16 block searched over 16 vertical offsets.
    localparam int ME_DEF_N  = 16;
    localparam int ME_DEF_NV = 16;

    // Ceiling log2 for elaboration-time width computation; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Search-memory address width: window pitch 2N times N+NV-1 rows.
    function automatic int search_addr_w(input int n, input int nv);
        return clog2(2 * n * (n + nv - 1));
    endfunction

endpackage

// File: rtl/me_step_counter.sv
// Enabled up-counter with synchronous clear that wraps at LAST and flags the terminal value.
// The next-count value is exported so the owner can register outputs with no extra latency.
module me_step_counter
    import me_pkg::*;
#(
    parameter int W    = 4,
    parameter int LAST = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count_next,
    output logic         tc
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] count_r;

    // Next count: clear has priority, then wrap or increment, otherwise hold.
    always_comb begin
        count_next = count_r;
        if (clr) begin
            count_next = W'(0);
        end else if (inc) begin
            if (count_r == LAST_V) begin
                count_next = W'(0);
            end else begin
                count_next = count_r + W'(1);
            end
        end else begin
            count_next = count_r;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= W'(0);
        end else begin
            count_r <= count_next;
        end
    end

    assign tc = (count_r == LAST_V);

endmodule

// File: rtl/me_ctrl_param.sv
// Full-search block-matching sequencer: streams an N x N reference block against NV
// vertical offsets of the search window, one horizontal offset per PE, then drains
// the PE results. Outputs are registered from the next state/count so they line up
// with the step they describe.
module me_ctrl_param
    import me_pkg::*;
#(
    parameter int N          = ME_DEF_N,
    parameter int NV         = ME_DEF_NV,
    parameter int SIGNED_VEC = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              en,
    output logic                              busy,
    output logic                              done,
    output logic                              comp_start,
    output logic [N-1:0]                      new_dist,
    output logic [N-1:0]                      pe_ready,
    output logic [N-1:0]                      s1s2_mux,
    output logic [clog2(N):0]                 vector_x,
    output logic [clog2(N):0]                 vector_y,
    output logic [2*clog2(N)-1:0]             addr_r,
    output logic [search_addr_w(N, NV)-1:0]   addr_s1,
    output logic [search_addr_w(N, NV)-1:0]   addr_s2
);

    localparam int LN    = clog2(N);
    localparam int LNV   = clog2(NV);
    localparam int SW    = 2 * N;
    localparam int AWR   = 2 * LN;
    localparam int AWS   = search_addr_w(N, NV);
    localparam int VW    = LN + 1;
    localparam int TW    = 2 * LN + LNV;
    localparam int TLAST = NV * N * N - 1;

    // Offsets that centre the candidate tags when signed vectors are requested.
    localparam logic [VW-1:0] XOFF  = (SIGNED_VEC != 0) ? VW'(N / 2) : VW'(0);
    localparam logic [VW-1:0] YOFF  = (SIGNED_VEC != 0) ? VW'(NV / 2) : VW'(0);
    localparam logic [VW-1:0] YLAST = VW'(NV - 1);

    me_state_e        state_r;
    me_state_e        state_next_s;

    logic [TW-1:0]    t_next_s;
    logic             t_tc_s;
    logic             t_clr_s;
    logic             t_inc_s;
    logic [LN-1:0]    d_next_s;
    logic             d_tc_s;
    logic             d_clr_s;
    logic             d_inc_s;

    logic [LN-1:0]    c_s;
    logic [LN-1:0]    r_s;
    logic [VW-1:0]    v_s;
    logic [AWS-1:0]   sweep_s1_s;

    logic [N-1:0]     new_dist_s;
    logic [N-1:0]     pe_ready_s;
    logic [N-1:0]     s1s2_mux_s;
    logic [VW-1:0]    vector_x_s;
    logic [VW-1:0]    vector_y_s;
    logic [AWR-1:0]   addr_r_s;
    logic [AWS-1:0]   addr_s1_s;
    logic [AWS-1:0]   addr_s2_s;

    // t only runs in SWEEP and d only in DRAIN; both sit at zero elsewhere.
    assign t_clr_s = (state_r != SWEEP);
    assign t_inc_s = (state_r == SWEEP) && en;
    assign d_clr_s = (state_r != DRAIN);
    assign d_inc_s = (state_r == DRAIN) && en;

    me_step_counter #(
        .W    (TW),
        .LAST (TLAST)
    ) u_t_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (t_clr_s),
        .inc        (t_inc_s),
        .count_next (t_next_s),
        .tc         (t_tc_s)
    );

    me_step_counter #(
        .W    (LN),
        .LAST (N - 1)
    ) u_d_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (d_clr_s),
        .inc        (d_inc_s),
        .count_next (d_next_s),
        .tc         (d_tc_s)
    );

    // Step decode: column, row and vertical offset are plain bit fields of t.
    assign c_s        = t_next_s[LN-1:0];
    assign r_s        = t_next_s[2*LN-1:LN];
    assign v_s        = VW'(t_next_s >> (2 * LN));
    assign sweep_s1_s = (AWS'(v_s) + AWS'(r_s)) * AWS'(SW) + AWS'(c_s);

    // Phase sequencing; start is only looked at in IDLE and en gates every advance.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SWEEP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SWEEP: begin
                if (en && t_tc_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = SWEEP;
                end
            end
            DRAIN: begin
                if (en && d_tc_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode for the upcoming cycle; DRAIN keeps the last sweep addresses.
    always_comb begin
        new_dist_s = {N{1'b0}};
        pe_ready_s = {N{1'b0}};
        s1s2_mux_s = {N{1'b0}};
        vector_x_s = VW'(0);
        vector_y_s = VW'(0);
        addr_r_s   = AWR'(0);
        addr_s1_s  = AWS'(0);
        addr_s2_s  = AWS'(0);
        case (state_next_s)
            SWEEP: begin
                addr_r_s  = {r_s, c_s};
                addr_s1_s = sweep_s1_s;
                addr_s2_s = sweep_s1_s + AWS'(N);
                for (int i = 0; i < N; i++) begin
                    s1s2_mux_s[i] = (int'(c_s) >= i);
                    new_dist_s[i] = (r_s == LN'(0)) && (int'(c_s) == i);
                end
                pe_ready_s = (v_s != VW'(0)) ? new_dist_s : {N{1'b0}};
                vector_x_s = VW'(c_s) - XOFF;
                vector_y_s = v_s - YOFF;
            end
            DRAIN: begin
                addr_r_s   = addr_r;
                addr_s1_s  = addr_s1;
                addr_s2_s  = addr_s2;
                s1s2_mux_s = s1s2_mux;
                vector_x_s = vector_x;
                pe_ready_s = {{(N-1){1'b0}}, 1'b1} << d_next_s;
                vector_y_s = YLAST - YOFF;
            end
            default: begin
                new_dist_s = {N{1'b0}};
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts any search.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            comp_start <= 1'b0;
            new_dist   <= {N{1'b0}};
            pe_ready   <= {N{1'b0}};
            s1s2_mux   <= {N{1'b0}};
            vector_x   <= VW'(0);
            vector_y   <= VW'(0);
            addr_r     <= AWR'(0);
            addr_s1    <= AWS'(0);
            addr_s2    <= AWS'(0);
        end else begin
            state_r    <= state_next_s;
            busy       <= (state_next_s != IDLE);
            done       <= (state_next_s == DONE);
            comp_start <= (state_r == IDLE) && start;
            new_dist   <= new_dist_s;
            pe_ready   <= pe_ready_s;
            s1s2_mux   <= s1s2_mux_s;
            vector_x   <= vector_x_s;
            vector_y   <= vector_y_s;
            addr_r     <= addr_r_s;
            addr_s1    <= addr_s1_s;
            addr_s2    <= addr_s2_s;
        end
    end

endmodule

// File: tb/tb_me_ctrl_param.sv
// Bench for me_ctrl_param: a 16x16/NV=16 unsigned instance under directed and random
// stimulus, plus an 8x8/NV=4 signed instance under random stimulus, both compared every
// cycle against a step-count model of the search.
module tb_me_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, en_a, rst_b, start_b, en_b;

    logic        busy_a, done_a, comp_start_a;
    logic [15:0] new_dist_a, pe_ready_a, s1s2_mux_a;
    logic [4:0]  vector_x_a, vector_y_a;
    logic [7:0]  addr_r_a;
    logic [9:0]  addr_s1_a, addr_s2_a;

    logic        busy_b, done_b, comp_start_b;
    logic [7:0]  new_dist_b, pe_ready_b, s1s2_mux_b;
    logic [3:0]  vector_x_b, vector_y_b;
    logic [5:0]  addr_r_b;
    logic [7:0]  addr_s1_b, addr_s2_b;

    me_ctrl_param #(.N(16), .NV(16), .SIGNED_VEC(0)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .en(en_a),
        .busy(busy_a), .done(done_a), .comp_start(comp_start_a),
        .new_dist(new_dist_a), .pe_ready(pe_ready_a), .s1s2_mux(s1s2_mux_a),
        .vector_x(vector_x_a), .vector_y(vector_y_a),
        .addr_r(addr_r_a), .addr_s1(addr_s1_a), .addr_s2(addr_s2_a)
    );

    me_ctrl_param #(.N(8), .NV(4), .SIGNED_VEC(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .en(en_b),
        .busy(busy_b), .done(done_b), .comp_start(comp_start_b),
        .new_dist(new_dist_b), .pe_ready(pe_ready_b), .s1s2_mux(s1s2_mux_b),
        .vector_x(vector_x_b), .vector_y(vector_y_b),
        .addr_r(addr_r_b), .addr_s1(addr_s1_b), .addr_s2(addr_s2_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit b_rand  = 1'b0;

    // instance geometry: N, NV, signed flag, search address width, vector width
    int n_p   [2] = '{16, 8};
    int nv_p  [2] = '{16, 4};
    int sg_p  [2] = '{0, 1};
    int aws_p [2] = '{10, 8};
    int vw_p  [2] = '{5, 4};

    // model: phase 0 idle, 1 searching (k enabled steps since start), 2 done cycle
    int ph [2]     = '{0, 0};
    int k_m [2]    = '{0, 0};
    int cs_m [2]   = '{0, 0};
    int stalls [2] = '{0, 0};
    int st_cyc [2] = '{0, 0};

    bit stall_map [0:8191];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] tag_val(input int x, input int off, input int w);
        return 64'((x - off) & ((1 << w) - 1));
    endfunction

    task automatic model_step(input int i, input bit r, input bit s, input bit e);
        int tot;
        tot = nv_p[i] * n_p[i] * n_p[i];
        if (r) begin
            ph[i] = 0; k_m[i] = 0; cs_m[i] = 0;
        end else begin
            case (ph[i])
                0: begin
                    cs_m[i] = s ? 1 : 0;
                    if (s) begin
                        ph[i] = 1; k_m[i] = 0; stalls[i] = 0; st_cyc[i] = cyc;
                    end
                end
                1: begin
                    cs_m[i] = 0;
                    if (e) begin
                        k_m[i]++;
                        if (k_m[i] == tot + n_p[i]) ph[i] = 2;
                    end else begin
                        stalls[i]++;
                    end
                end
                default: begin
                    cs_m[i] = 0; ph[i] = 0;
                end
            endcase
        end
    endtask

    task automatic compare_inst(input int i);
        logic [63:0] got [11];
        logic [63:0] ex [11];
        string nm [11] = '{"busy", "done", "comp_start", "new_dist", "pe_ready", "s1s2_mux",
                           "vector_x", "vector_y", "addr_r", "addr_s1", "addr_s2"};
        bit in_drain;
        int n, nv, tot, t, v, r, c, s1;
        n = n_p[i]; nv = nv_p[i]; tot = nv * n * n;
        in_drain = 1'b0;
        if (i == 0) begin
            got = '{64'(busy_a), 64'(done_a), 64'(comp_start_a), 64'(new_dist_a), 64'(pe_ready_a),
                    64'(s1s2_mux_a), 64'(vector_x_a), 64'(vector_y_a), 64'(addr_r_a),
                    64'(addr_s1_a), 64'(addr_s2_a)};
        end else begin
            got = '{64'(busy_b), 64'(done_b), 64'(comp_start_b), 64'(new_dist_b), 64'(pe_ready_b),
                    64'(s1s2_mux_b), 64'(vector_x_b), 64'(vector_y_b), 64'(addr_r_b),
                    64'(addr_s1_b), 64'(addr_s2_b)};
        end
        for (int j = 0; j < 11; j++) ex[j] = 64'd0;
        ex[2] = 64'(cs_m[i]);
        if (ph[i] == 1) begin
            ex[0] = 64'd1;
            t = (k_m[i] < tot) ? k_m[i] : tot - 1;
            v = t / (n * n); r = (t / n) % n; c = t % n;
            s1 = (v + r) * 2 * n + c;
            ex[8]  = 64'(r * n + c);
            ex[9]  = 64'(s1);
            ex[10] = 64'((s1 + n) % (1 << aws_p[i]));
            if (k_m[i] < tot) begin
                ex[3] = ((t % (n * n)) < n) ? (64'd1 << (t % (n * n))) : 64'd0;
                ex[4] = (v >= 1) ? ex[3] : 64'd0;
                ex[5] = (64'd1 << (c + 1)) - 64'd1;
                ex[6] = tag_val(c, sg_p[i] ? n / 2 : 0, vw_p[i]);
                ex[7] = tag_val(v, sg_p[i] ? nv / 2 : 0, vw_p[i]);
            end else begin
                in_drain = 1'b1;
                ex[4] = 64'd1 << (k_m[i] - tot);
                ex[7] = tag_val(nv - 1, sg_p[i] ? nv / 2 : 0, vw_p[i]);
            end
        end else if (ph[i] == 2) begin
            ex[0] = 64'd1;
            ex[1] = 64'd1;
        end
        for (int j = 0; j < 11; j++) begin
            if (!(in_drain && (j == 5 || j == 6)))
                check_val($sformatf("%s_%s", (i == 0) ? "a" : "b", nm[j]), got[j], ex[j]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, rst_a, start_a, en_a);
        model_step(1, rst_b, start_b, en_b);
        cyc++;
        @(negedge clk);
        compare_inst(0);
        compare_inst(1);
        if (done_a) check_val("a_latency", 64'(cyc - st_cyc[0]), 64'(16*16*16 + 16 + 1 + stalls[0]));
        if (done_b) check_val("b_latency", 64'(cyc - st_cyc[1]), 64'(4*8*8 + 8 + 1 + stalls[1]));
        if (b_rand) begin
            start_b = ($urandom % 20) == 0;
            en_b    = ($urandom % 4) != 0;
            rst_b   = ($urandom % 500) == 0;
        end
    endtask

    task automatic wait_done_a(input int budget);
        int cnt;
        cnt = 0;
        while (!done_a && cnt < budget) begin
            cycle();
            cnt++;
        end
        check_val("a_done_seen", 64'(done_a), 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int base;
        rst_a = 1'b1; start_a = 1'b0; en_a = 1'b1;
        rst_b = 1'b1; start_b = 1'b0; en_b = 1'b1;
        @(negedge clk);
        // reset wins over start/en
        start_a = 1'b1; start_b = 1'b1;
        repeat (3) cycle();
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        cycle();

        // full search with en held high, both instances started together
        start_a = 1'b1; start_b = 1'b1;
        cycle();
        start_a = 1'b0; start_b = 1'b0;
        check_val("t0_comp_start", 64'(comp_start_a), 64'd1);
        check_val("t0_addr_r", 64'(addr_r_a), 64'd0);
        check_val("t0_addr_s2", 64'(addr_s2_a), 64'd16);
        check_val("t0_new_dist", 64'(new_dist_a), 64'h0001);
        check_val("t0_s1s2_mux", 64'(s1s2_mux_a), 64'h0001);
        repeat (261) cycle();
        check_val("t261_pe_ready", 64'(pe_ready_a), 64'h0020);
        check_val("t261_addr_s1", 64'(addr_s1_a), 64'd37);
        check_val("t261_vector_y", 64'(vector_y_a), 64'd1);
        repeat (4099 - 261) cycle();
        check_val("d3_pe_ready", 64'(pe_ready_a), 64'h0008);
        wait_done_a(200);
        cycle();
        b_rand = 1'b1;

        // stall windows: 20 x 7 cycles inside the sweep
        for (int q = 0; q < 8192; q++) stall_map[q] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            base = 100 + j * 190 + int'($urandom_range(0, 150));
            for (int q = 0; q < 7; q++) stall_map[base + q] = 1'b1;
        end
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        cnt = 0;
        while (!done_a && cnt < 6000) begin
            en_a = !stall_map[cnt];
            cycle();
            cnt++;
        end
        en_a = 1'b1;
        check_val("stall_done_seen", 64'(done_a), 64'd1);
        check_val("stall_latency", 64'(cyc - st_cyc[0]), 64'(4113 + 140));
        cycle();

        // reset mid-search, restart, ignored second start
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        repeat (1000) cycle();
        rst_a = 1'b1;
        cycle();
        rst_a = 1'b0;
        check_val("rst_busy", 64'(busy_a), 64'd0);
        repeat (20) cycle();
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        check_val("restart_addr_s2", 64'(addr_s2_a), 64'd16);
        check_val("restart_new_dist", 64'(new_dist_a), 64'h0001);
        repeat (500) cycle();
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        check_val("ignored_start_comp", 64'(comp_start_a), 64'd0);
        wait_done_a(5000);
        cycle();

        // random traffic on both instances
        for (int j = 0; j < 12000; j++) begin
            start_a = ($urandom % 50) == 0;
            en_a    = ($urandom % 8) != 0;
            rst_a   = ($urandom % 3000) == 0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
